dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory of the multicycle i281 CPU between two requesters: the CPU control FSM (MemREAD/MemWRITE states) and the debug/loader port (memory preload and display readback).
- CPU has fixed priority. A starvation counter guarantees the debug port a grant after STARVE_LIMIT consecutive losses.
- Exposes a stall flag so the control FSM holds its Mem state until its access completes.

Parameters:
ADDR_W, 4, data memory address width
DATA_W, 8, data word width
STARVE_LIMIT, 4, consecutive CPU-won contentions before debug is forced through (1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  registered read data, valid with cpu_ack, held afterwards
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
dbg_req  in  1  debug access request; held until dbg_ack
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack, held afterwards
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
busy  out  1  high in ISSUE and RESP
owner  out  1  0 = CPU, 1 = debug; holds the last grantee

Behaviour:
- Reset (async): state = IDLE. All outputs 0, including both rdata registers, latched address/we/wdata, owner, and starve_cnt (4 bits).
- States are IDLE, ISSUE and RESP. All transitions occur on the rising clock edge and are evaluated from the current-cycle inputs.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant debug if starve_cnt >= STARVE_LIMIT, otherwise grant CPU.
  - On grant: latch the winner's we/addr/wdata into internal registers, set owner, go to ISSUE.
- Starvation counter:
  - Increments (saturating at 15) on a CPU grant while dbg_req = 1.
  - Clears on any debug grant, and on any IDLE cycle with dbg_req = 0.
- ISSUE (1 cycle):
  - mem_en = 1 and mem_we = latched we.
  - mem_addr and mem_wdata are driven from the latched registers.
  - Always go to RESP.
- RESP (1 cycle):
  - On a read, capture mem_rdata into the owner's rdata register. The other port's rdata is untouched.
  - Pulse the owner's ack for this cycle.
  - Always go to IDLE.
- Outside ISSUE: mem_en = 0 and mem_we = 0; mem_addr and mem_wdata hold their latched values.
- Latency and throughput:
  - Request seen in IDLE at cycle n gives ISSUE at n+1 and ack at n+2.
  - Minimum of 3 cycles per access. There is always one IDLE cycle between accesses.
- Handshake:
  - A requester holds req and its fields stable until it sees ack.
  - req still high in the IDLE cycle after ack is treated as a new request.
  - Field changes during ISSUE or RESP are ignored because the fields were latched at grant.
  - Dropping req before ack does not cancel an access already granted. The ack still pulses.
- Never both acks in the same cycle. Never more than one access outstanding.
- Reset asserted in ISSUE or RESP aborts the access:
  - mem_we drops immediately.
  - No ack is produced.
  - An aborted write may or may not have reached memory; software must not rely on it.

Test Plan:
- CPU read alone, mem[3] = 0x5A, cpu_req/addr = 3 asserted in IDLE at cycle 0 -> mem_en = 1, mem_addr = 3 at cycle 1; cpu_ack = 1, cpu_rdata = 0x5A at cycle 2; cpu_stall = 1 in cycles 0-1; dbg_rdata stays 0x00.
- Debug write addr 7, data 0xC3 -> mem_we = 1, mem_wdata = 0xC3 at cycle 1; dbg_ack at cycle 2. A following CPU read of addr 7 returns cpu_rdata = 0xC3.
- Both req held high, STARVE_LIMIT = 4, each requester re-requesting after its ack -> grant order CPU, CPU, CPU, CPU, DBG, CPU ×4, DBG, ...; owner toggles accordingly; no cycle has both acks.
- CPU req held continuously alone -> cpu_ack at cycles 2, 5, 8; starve_cnt stays 0.
- CPU write addr 2, data 0x11; reset pulsed during the ISSUE cycle -> mem_we falls within the same cycle; no cpu_ack; state IDLE; all outputs 0 after reset.
- Debug drops req during RESP, changes dbg_addr during ISSUE -> the access uses the latched address, dbg_ack still pulses once, and no second access starts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the i281 single-port data memory between the CPU FSM (fixed priority)
// and the debug/loader port, forcing debug through after STARVE_LIMIT consecutive losses.
module dmem_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t            state_q;
  logic              we_q, owner_q, grant_dbg, rd_resp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic [3:0]        starve_q, starve_d;
  always_comb begin
    grant_dbg = dbg_req & (~cpu_req | (starve_q >= LIMIT));
    starve_d  = (dbg_req & ~grant_dbg) ? starve_q + 4'(starve_q != 4'hf) : 4'h0;
    rd_resp   = (state_q == RESP) & ~we_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      starve_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (cpu_req | dbg_req) begin
            state_q <= ISSUE;
            owner_q <= grant_dbg;
            we_q    <= grant_dbg ? dbg_we : cpu_we;
            addr_q  <= grant_dbg ? dbg_addr : cpu_addr;
            wdata_q <= grant_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ISSUE: state_q <= RESP;
        default: begin
          state_q <= IDLE;
          if (rd_resp & ~owner_q) cpu_rdata_q <= mem_rdata;
          if (rd_resp & owner_q) dbg_rdata_q <= mem_rdata;
        end
      endcase
    end
  end
  // read data bypasses the capture register during RESP so it is valid alongside the ack
  assign mem_en    = state_q == ISSUE;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != IDLE;
  assign owner     = owner_q;
  assign cpu_ack   = (state_q == RESP) & ~owner_q;
  assign dbg_ack   = (state_q == RESP) & owner_q;
  assign cpu_rdata = (rd_resp & ~owner_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (rd_resp & owner_q) ? mem_rdata : dbg_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-port traffic against a transaction-level schedule model
// (grant at cycle g, memory strobe at g+1, ack at g+2, next decision at g+3).
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  logic       clock = 1'b0, reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [3:0] cpu_addr = '0, dbg_addr = '0;
  logic [7:0] cpu_wdata = '0, dbg_wdata = '0;
  logic       cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, busy, owner;
  logic [7:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );
  always #5 clock = ~clock;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  always @(posedge clock) begin
    if (reset) for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    else if (mem_en & mem_we) mem[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= mem[mem_addr];
  end
  int checks = 0, errors = 0, cyc = 0, t_g = -3, starve = 0, cpu_p = 0, dbg_p = 0;
  bit scr = 1'b0;
  logic       g_dbg = 1'b0, g_we = 1'b0, e_owner = 1'b0;
  logic [3:0] g_addr = '0, e_addr = '0;
  logic [7:0] g_wd = '0, g_rd = '0, g_old = '0, e_wdata = '0, e_cpu_rd = '0, e_dbg_rd = '0;
  logic       n_cr, n_cw, n_dr, n_dw;
  logic [3:0] n_ca, n_da;
  logic [7:0] n_cd, n_dd;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic check_all();
    int  a   = cyc - t_g;
    bit  iss = (a == 1);
    bit  rsp = (a == 2);
    if (rsp && !g_we) begin
      if (g_dbg) e_dbg_rd = g_rd;
      else e_cpu_rd = g_rd;
    end
    chk("mem_en", 32'(mem_en), 32'(iss));
    chk("mem_we", 32'(mem_we), 32'(iss & g_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("cpu_ack", 32'(cpu_ack), 32'(rsp & !g_dbg));
    chk("dbg_ack", 32'(dbg_ack), 32'(rsp & g_dbg));
    chk("busy", 32'(busy), 32'(iss | rsp));
    chk("owner", 32'(owner), 32'(e_owner));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & !(rsp & !g_dbg)));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rd));
    chk("dbg_rdata", 32'(dbg_rdata), 32'(e_dbg_rd));
  endtask
  // decision for the clock edge that ends the current cycle, from the live inputs
  task automatic model_step();
    if (cyc - t_g >= 3) begin
      if (!dbg_req) starve = 0;
      if (cpu_req || dbg_req) begin
        g_dbg = dbg_req && (!cpu_req || starve >= LIMIT);
        if (g_dbg) starve = 0;
        else if (dbg_req && starve < 15) starve++;
        g_we   = g_dbg ? dbg_we : cpu_we;
        g_addr = g_dbg ? dbg_addr : cpu_addr;
        g_wd   = g_dbg ? dbg_wdata : cpu_wdata;
        g_rd   = ref_mem[g_addr];
        g_old  = g_rd;
        if (g_we) ref_mem[g_addr] = g_wd;
        e_owner = g_dbg;
        e_addr  = g_addr;
        e_wdata = g_wd;
        t_g     = cyc;
      end
    end
  endtask
  task automatic plan(input logic ack, input logic infl, input logic req, input logic we,
                      input logic [3:0] a, input logic [7:0] d, input int p,
                      output logic o_req, output logic o_we, output logic [3:0] o_a,
                      output logic [7:0] o_d);
    o_req = req; o_we = we; o_a = a; o_d = d;
    if (ack || (!req && !infl)) begin
      o_req = int'($urandom_range(99)) < p;
      o_we  = 1'($urandom_range(1));
      o_a   = 4'($urandom_range(15));
      o_d   = 8'($urandom_range(255));
    end else if (infl && scr) begin
      if ($urandom_range(1) == 1) begin
        o_we = 1'($urandom_range(1));
        o_a  = 4'($urandom_range(15));
        o_d  = 8'($urandom_range(255));
      end
      if ($urandom_range(3) == 0) o_req = 1'b0;
    end
  endtask
  task automatic cycle();
    bit infl = (cyc - t_g >= 0) && (cyc - t_g <= 1);
    model_step();
    infl = (cyc - t_g >= 0) && (cyc - t_g <= 1);
    plan(cpu_ack, infl && !g_dbg, cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_p, n_cr, n_cw, n_ca, n_cd);
    plan(dbg_ack, infl && g_dbg, dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_p, n_dr, n_dw, n_da, n_dd);
    @(posedge clock);
    #1;
    cpu_req = n_cr; cpu_we = n_cw; cpu_addr = n_ca; cpu_wdata = n_cd;
    dbg_req = n_dr; dbg_we = n_dw; dbg_addr = n_da; dbg_wdata = n_dd;
    cyc++;
    @(negedge clock);
    check_all();
  endtask
  initial begin
    int       n = 0;
    int       seq [10];
    logic [7:0] old2;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'($urandom_range(255));
    ref_mem[3] = 8'h5a;
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    repeat (2) cycle();
    chk("read_5a", 32'(cpu_rdata), 32'h5a);
    chk("read_dbg_untouched", 32'(dbg_rdata), 32'h0);
    cycle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd7; dbg_wdata = 8'hc3;
    cycle();
    chk("dbg_write_data", 32'(mem_wdata), 32'hc3);
    repeat (2) cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
    repeat (2) cycle();
    chk("read_after_dbg_write", 32'(cpu_rdata), 32'hc3);
    repeat (2) cycle();
    cpu_p = 100; dbg_p = 100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd9;
    for (int k = 0; k < 60 && n < 10; k++) begin
      cycle();
      if (cpu_ack) begin seq[n] = 0; n++; end
      else if (dbg_ack) begin seq[n] = 1; n++; end
    end
    chk("starve_count", 32'(n), 32'd10);
    for (int i = 0; i < n; i++) chk("starve_order", 32'(seq[i]), 32'(i % 5 == 4));
    cpu_p = 0; dbg_p = 0;
    repeat (8) cycle();
    scr = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cpu_p = int'($urandom_range(20, 100));
      dbg_p = int'($urandom_range(20, 100));
      repeat (600) cycle();
    end
    cpu_p = 0; dbg_p = 0; scr = 1'b0;
    repeat (10) cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 8'h11;
    cycle();
    chk("abort_issue_we", 32'(mem_we), 32'd1);
    #1;
    reset = 1'b1;
    cpu_req = 1'b0;
    ref_mem[2] = g_old;
    old2 = g_old;
    t_g = cyc - 3; starve = 0; e_owner = 1'b0; e_addr = '0; e_wdata = '0;
    e_cpu_rd = '0; e_dbg_rd = '0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", 32'(mem_wdata), 32'd0);
    chk("abort_owner", 32'(owner), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc++;
    check_all();
    cycle();
    chk("abort_no_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd2;
    repeat (2) cycle();
    chk("abort_old_value", 32'(cpu_rdata), 32'(old2));
    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
